// File: rtl/trdb_stage_regs_if.sv
// Retirement port of the trace staging pipe: core-side handshake and
// instruction payload plus downstream stall/flush controls.
interface trdb_stage_regs_if #(
  parameter int XLEN = 32
);
  logic            inst_valid_i;
  logic            ready_o;
  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] iaddr_i;
  logic [XLEN-1:0] inst_data_i;
  logic            compressed_i;
  logic            exception_i;

  modport master (
    output inst_valid_i,
    output stall_i,
    output flush_i,
    output iaddr_i,
    output inst_data_i,
    output compressed_i,
    output exception_i,
    input  ready_o
  );

  modport slave (
    input  inst_valid_i,
    input  stall_i,
    input  flush_i,
    input  iaddr_i,
    input  inst_data_i,
    input  compressed_i,
    input  exception_i,
    output ready_o
  );
endinterface

// File: rtl/trdb_stage_regs.sv
// Trace encoder staging pipe: last/this/next-cycle views of the retired
// instruction stream, advancing only on an accepted retirement.
module trdb_stage_regs #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  trdb_stage_regs_if.slave bus,
  output logic            lc_ready_o,
  output logic            tc_ready_o,
  output logic            nc_ready_o,
  output logic [XLEN-1:0] lc_iaddr_o,
  output logic [XLEN-1:0] tc_iaddr_o,
  output logic [XLEN-1:0] nc_iaddr_o,
  output logic [XLEN-1:0] nc_inst_data_o,
  output logic            tc_compressed_o,
  output logic            nc_compressed_o,
  output logic            lc_exception_o,
  output logic            tc_exception_o,
  output logic            nc_exception_o,
  output logic            shifted_o,
  output logic [1:0]      fill_o
);

  logic accept;

  assign bus.ready_o = !bus.stall_i;
  assign accept      = bus.inst_valid_i && !bus.stall_i;

  // Fields with no downstream consumer (lc data/compressed, tc data)
  // are not stored; they could never be observed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lc_ready_o      <= 1'b0;
      tc_ready_o      <= 1'b0;
      nc_ready_o      <= 1'b0;
      lc_iaddr_o      <= '0;
      tc_iaddr_o      <= '0;
      nc_iaddr_o      <= '0;
      nc_inst_data_o  <= '0;
      tc_compressed_o <= 1'b0;
      nc_compressed_o <= 1'b0;
      lc_exception_o  <= 1'b0;
      tc_exception_o  <= 1'b0;
      nc_exception_o  <= 1'b0;
      shifted_o       <= 1'b0;
      fill_o          <= 2'd0;
    end else if (bus.flush_i) begin
      lc_ready_o      <= 1'b0;
      tc_ready_o      <= 1'b0;
      lc_iaddr_o      <= '0;
      tc_iaddr_o      <= '0;
      tc_compressed_o <= 1'b0;
      lc_exception_o  <= 1'b0;
      tc_exception_o  <= 1'b0;
      if (accept) begin
        nc_ready_o      <= 1'b1;
        nc_iaddr_o      <= bus.iaddr_i;
        nc_inst_data_o  <= bus.inst_data_i;
        nc_compressed_o <= bus.compressed_i;
        nc_exception_o  <= bus.exception_i;
        shifted_o       <= 1'b1;
        fill_o          <= 2'd1;
      end else begin
        nc_ready_o      <= 1'b0;
        nc_iaddr_o      <= '0;
        nc_inst_data_o  <= '0;
        nc_compressed_o <= 1'b0;
        nc_exception_o  <= 1'b0;
        shifted_o       <= 1'b0;
        fill_o          <= 2'd0;
      end
    end else if (accept) begin
      lc_ready_o      <= tc_ready_o;
      lc_iaddr_o      <= tc_iaddr_o;
      lc_exception_o  <= tc_exception_o;
      tc_ready_o      <= nc_ready_o;
      tc_iaddr_o      <= nc_iaddr_o;
      tc_compressed_o <= nc_compressed_o;
      tc_exception_o  <= nc_exception_o;
      nc_ready_o      <= 1'b1;
      nc_iaddr_o      <= bus.iaddr_i;
      nc_inst_data_o  <= bus.inst_data_i;
      nc_compressed_o <= bus.compressed_i;
      nc_exception_o  <= bus.exception_i;
      shifted_o       <= 1'b1;
      fill_o          <= (fill_o == 2'd3) ? 2'd3 : fill_o + 2'd1;
    end else begin
      shifted_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trdb_stage_regs.sv
// Directed bench for trdb_stage_regs: scoreboard of expected stage
// snapshots plus spot checks of the named scenarios.
module tb_trdb_stage_regs;

  typedef struct packed {
    logic        lr;
    logic        tr;
    logic        nr;
    logic [31:0] la;
    logic [31:0] ta;
    logic [31:0] na;
    logic [31:0] nd;
    logic        tc;
    logic        nc;
    logic        le;
    logic        te;
    logic        ne;
    logic        sh;
    logic [1:0]  fill;
  } snap_t;

  logic clk = 1'b0;
  logic rst_i;

  logic        lc_ready, tc_ready, nc_ready;
  logic [31:0] lc_iaddr, tc_iaddr, nc_iaddr, nc_data;
  logic        tc_cmp, nc_cmp, lc_exc, tc_exc, nc_exc;
  logic        shifted;
  logic [1:0]  fill;

  int checks = 0;
  int errors = 0;

  snap_t model;
  snap_t sb[$];

  always #5 clk = ~clk;

  trdb_stage_regs_if #(.XLEN(32)) bus ();

  trdb_stage_regs #(.XLEN(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .bus             (bus.slave),
    .lc_ready_o      (lc_ready),
    .tc_ready_o      (tc_ready),
    .nc_ready_o      (nc_ready),
    .lc_iaddr_o      (lc_iaddr),
    .tc_iaddr_o      (tc_iaddr),
    .nc_iaddr_o      (nc_iaddr),
    .nc_inst_data_o  (nc_data),
    .tc_compressed_o (tc_cmp),
    .nc_compressed_o (nc_cmp),
    .lc_exception_o  (lc_exc),
    .tc_exception_o  (tc_exc),
    .nc_exception_o  (nc_exc),
    .shifted_o       (shifted),
    .fill_o          (fill)
  );

  function automatic snap_t observe();
    snap_t s;
    s.lr = lc_ready;  s.tr = tc_ready;  s.nr = nc_ready;
    s.la = lc_iaddr;  s.ta = tc_iaddr;  s.na = nc_iaddr;
    s.nd = nc_data;   s.tc = tc_cmp;    s.nc = nc_cmp;
    s.le = lc_exc;    s.te = tc_exc;    s.ne = nc_exc;
    s.sh = shifted;   s.fill = fill;
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Reference behaviour, pushed before the edge and compared after it.
  task automatic step(input logic r, input logic f, input logic s,
                      input logic v, input logic [31:0] a,
                      input logic c, input logic e);
    snap_t exp_s;
    snap_t got;
    logic  acc;
    rst_i            = r;
    bus.flush_i      = f;
    bus.stall_i      = s;
    bus.inst_valid_i = v;
    bus.iaddr_i      = a;
    bus.inst_data_i  = data_of(a);
    bus.compressed_i = c;
    bus.exception_i  = e;
    #1;
    check("ready_o", {63'd0, bus.ready_o}, {63'd0, !s});
    acc = v && !s;
    if (r) begin
      model = '0;
    end else if (f) begin
      model = '0;
      if (acc) begin
        model.nr = 1'b1; model.na = a; model.nd = data_of(a);
        model.nc = c; model.ne = e; model.sh = 1'b1; model.fill = 2'd1;
      end
    end else if (acc) begin
      model.lr = model.tr; model.la = model.ta; model.le = model.te;
      model.tr = model.nr; model.ta = model.na;
      model.tc = model.nc; model.te = model.ne;
      model.nr = 1'b1; model.na = a; model.nd = data_of(a);
      model.nc = c; model.ne = e; model.sh = 1'b1;
      if (model.fill != 2'd3) model.fill = model.fill + 2'd1;
    end else begin
      model.sh = 1'b0;
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    exp_s = sb.pop_front();
    got   = observe();
    checks++;
    assert (got === exp_s) else begin
      errors++;
      $error("FAIL snapshot observed %0h expected %0h", got, exp_s);
    end
  endtask

  task automatic acc(input logic [31:0] a, input logic c, input logic e);
    step(1'b0, 1'b0, 1'b0, 1'b1, a, c, e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    model = '0;
    rst_i = 1'b1;
    bus.flush_i = 1'b0; bus.stall_i = 1'b0; bus.inst_valid_i = 1'b0;
    bus.iaddr_i = '0; bus.inst_data_i = '0;
    bus.compressed_i = 1'b0; bus.exception_i = 1'b0;
    @(posedge clk);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 1'b1);
    check("rst_fill", {62'd0, fill}, 64'd0);
    check("rst_nc_ready", {63'd0, nc_ready}, 64'd0);

    // reset mid-fill
    acc(32'h100, 1'b0, 1'b0);
    acc(32'h104, 1'b0, 1'b0);
    check("mid_fill", {62'd0, fill}, 64'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0);
    check("mid_rst_ready", {61'd0, lc_ready, tc_ready, nc_ready}, 64'd0);
    check("mid_rst_fill", {62'd0, fill}, 64'd0);
    check("mid_rst_iaddr", {32'd0, lc_iaddr | tc_iaddr | nc_iaddr}, 64'd0);

    // fill and shift
    acc(32'h100, 1'b0, 1'b0);
    check("fill1_nc", {63'd0, nc_ready}, 64'd1);
    check("fill1_tc", {63'd0, tc_ready}, 64'd0);
    acc(32'h104, 1'b0, 1'b0);
    acc(32'h108, 1'b0, 1'b0);
    check("fill3_lc", {63'd0, lc_ready}, 64'd1);
    acc(32'h10A, 1'b1, 1'b0);
    check("shift_lc", {32'd0, lc_iaddr}, 64'h104);
    check("shift_tc", {32'd0, tc_iaddr}, 64'h108);
    check("shift_nc", {32'd0, nc_iaddr}, 64'h10A);
    check("shift_ncmp", {63'd0, nc_cmp}, 64'd1);
    check("shift_fill", {62'd0, fill}, 64'd3);
    check("shift_pulse", {63'd0, shifted}, 64'd1);

    // idle hold
    for (int i = 0; i < 5; i++) begin
      idle();
      check("idle_shifted", {63'd0, shifted}, 64'd0);
    end
    check("idle_lc", {32'd0, lc_iaddr}, 64'h104);
    check("idle_nc", {32'd0, nc_iaddr}, 64'h10A);

    // stall with pending retirement
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    check("stall_nc", {32'd0, nc_iaddr}, 64'h10A);
    check("stall_shifted", {63'd0, shifted}, 64'd0);
    acc(32'h200, 1'b0, 1'b0);
    check("unstall_nc", {32'd0, nc_iaddr}, 64'h200);
    check("unstall_lc", {32'd0, lc_iaddr}, 64'h108);

    // flush with valid input
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
    check("flush_nc", {32'd0, nc_iaddr}, 64'h300);
    check("flush_nexc", {63'd0, nc_exc}, 64'd1);
    check("flush_ready", {61'd0, lc_ready, tc_ready, nc_ready}, 64'd1);
    check("flush_fill", {62'd0, fill}, 64'd1);
    check("flush_shifted", {63'd0, shifted}, 64'd1);

    // flush without input, and flush while stalled
    acc(32'h304, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h308, 1'b0, 1'b0);
    check("flush_idle_fill", {62'd0, fill}, 64'd0);
    acc(32'h310, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h314, 1'b0, 1'b0);
    check("flush_stall_nr", {63'd0, nc_ready}, 64'd0);
    check("flush_stall_na", {32'd0, nc_iaddr}, 64'd0);

    // repeat address
    acc(32'h400, 1'b0, 1'b0);
    acc(32'h400, 1'b0, 1'b0);
    check("rep_tc", {32'd0, tc_iaddr}, 64'h400);
    check("rep_nc", {32'd0, nc_iaddr}, 64'h400);
    check("rep_ready", {62'd0, tc_ready, nc_ready}, 64'd3);
    check("rep_shifted", {63'd0, shifted}, 64'd1);

    // mixed traffic against the scoreboard
    for (int i = 0; i < 60; i++)
      step(1'b0, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
           $urandom & 32'hFFFF_FFFE, 1'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
